// File: rtl/cs_word_pipe.sv
// cs_word_pipe: control-word pipeline between the microcode decoder and the
// cs field mapper. Bubble-collapsing valid/ready stages with stall and flush.
// One-shot strobe fields are replaced by their idle values while a word is
// held at the output, so each strobe fires exactly once per word.
module cs_word_pipe #(
  parameter int                    CW_WIDTH    = 65,
  parameter int                    STAGES      = 2,
  parameter logic [CW_WIDTH-1:0]   NOP_WORD    = 65'h0_0000_0001_0000_0010,
  parameter logic [CW_WIDTH-1:0]   STROBE_MASK = 65'h1_C190_0781_3020_0010,
  localparam int                   OCC_W       = $clog2(STAGES + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CW_WIDTH-1:0] in_word,
  input  logic                stall,
  input  logic                flush,
  output logic                out_valid,
  output logic                out_first,
  output logic [CW_WIDTH-1:0] out_word,
  output logic [OCC_W-1:0]    occupancy
);

  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0]   r_valid;
  logic [CW_WIDTH-1:0] r_data [STAGES];
  logic                r_first;
  logic [OCC_W-1:0]    r_occ;

  logic [STAGES:0]     w_adv;
  logic [STAGES-1:0]   w_in_vld;
  logic [CW_WIDTH-1:0] w_in_data [STAGES];
  logic                w_accept;
  logic                w_take;
  logic [CW_WIDTH-1:0] w_out_word;

  // Held words keep their selector fields but drop strobes back to idle.
  function automatic logic [CW_WIDTH-1:0] f_hold_filter(input logic [CW_WIDTH-1:0] word);
    return (word & ~STROBE_MASK) | (NOP_WORD & STROBE_MASK);
  endfunction

  // Stage k can move when any stage from k to the output has a hole, or the
  // consumer is taking; written without a self-referencing chain.
  always_comb begin
    logic w_free;
    w_adv = '0;
    w_adv[STAGES] = !stall;
    for (int k = 0; k < STAGES; k++) begin
      w_free = !stall;
      for (int j = k; j < STAGES; j++) begin
        w_free = w_free || !r_valid[j];
      end
      w_adv[k] = w_free;
    end
  end

  assign in_ready = rst_n && !flush && w_adv[0];
  assign w_accept = in_valid && in_ready;
  assign w_take   = r_valid[LAST] && !stall;

  // What each stage would load: the decoder input for stage 0, the previous stage otherwise.
  for (genvar g = 0; g < STAGES; g++) begin : g_in
    if (g == 0) begin : g_head
      assign w_in_vld[g]  = w_accept;
      assign w_in_data[g] = in_word;
    end else begin : g_body
      assign w_in_vld[g]  = r_valid[g-1];
      assign w_in_data[g] = r_data[g-1];
    end
  end

  // Stage registers, first-cycle marker and occupancy counter; flush empties the pipe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_first <= 1'b0;
      r_occ   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_data[k] <= NOP_WORD;
      end
    end else if (flush) begin
      r_valid <= '0;
      r_first <= 1'b0;
      r_occ   <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_adv[k]) begin
          r_valid[k] <= w_in_vld[k];
          if (w_in_vld[k]) begin
            r_data[k] <= w_in_data[k];
          end
        end
      end
      // A word newly arriving at the output is fresh; one that stays is held.
      r_first <= w_adv[LAST] ? w_in_vld[LAST] : 1'b0;
      r_occ   <= r_occ + OCC_W'(w_accept) - OCC_W'(w_take);
    end
  end

  // Output word from registers only: idle when empty, exact on first cycle, strobe-filtered while held.
  always_comb begin
    w_out_word = NOP_WORD;
    if (r_valid[LAST]) begin
      w_out_word = r_first ? r_data[LAST] : f_hold_filter(r_data[LAST]);
    end
  end

  assign out_valid = r_valid[LAST];
  assign out_first = r_first;
  assign out_word  = w_out_word;
  assign occupancy = r_occ;

endmodule

// File: tb/tb_cs_word_pipe.sv
// Bench for cs_word_pipe: directed stimulus feeds a scoreboard queue, a
// negedge monitor checks every output cycle against it.
module tb_cs_word_pipe;

  localparam int          CW   = 65;
  localparam int          ST   = 2;
  localparam logic [64:0] NOP  = 65'h0_0000_0001_0000_0010;
  localparam logic [64:0] MASK = 65'h1_C190_0781_3020_0010;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_word;
  logic          stall;
  logic          flush;
  logic          out_valid;
  logic          out_first;
  logic [CW-1:0] out_word;
  logic [1:0]    occupancy;

  typedef struct {
    logic [64:0] w;
    int          cyc;
    bit          chk_lat;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        m_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          mon_en = 0;
  bit          chk_lat = 0;
  bit          held = 0;
  logic [64:0] vec [6];

  cs_word_pipe #(
    .CW_WIDTH(CW),
    .STAGES(ST),
    .NOP_WORD(NOP),
    .STROBE_MASK(MASK)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_word(in_word),
    .stall(stall),
    .flush(flush),
    .out_valid(out_valid),
    .out_first(out_first),
    .out_word(out_word),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Record an accepted word, then advance one clock.
  task automatic edge_step();
    #1;
    if (in_valid && in_ready) sb_q.push_back(exp_t'{in_word, cyc, chk_lat});
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every output cycle against the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got word %h, required no valid output", out_word);
        end else begin
          m_e = sb_q[0];
          check("out_first", out_first, !held);
          if (!held) begin
            check("out_word_first", out_word, m_e.w);
            if (m_e.chk_lat) check("latency", cyc - m_e.cyc, ST);
          end else begin
            check("out_word_held", out_word, (m_e.w & ~MASK) | (NOP & MASK));
          end
          if (flush || !rst_n) held = 0;
          else if (!stall) begin
            void'(sb_q.pop_front());
            held = 0;
          end else held = 1;
        end
      end else begin
        check("out_valid_idle", out_valid, 1'b0);
        check("idle_word", out_word, NOP);
      end
      if (flush || !rst_n) begin
        sb_q.delete();
        held = 0;
      end
    end
  end

  initial begin
    vec[0] = 65'h0_0000_0100_0020_0000;
    vec[1] = 65'h1_FFFF_FFFF_FFFF_FFFF;
    vec[2] = 65'h0_1234_5678_9ABC_DEF0;
    vec[3] = 65'h1_C190_0781_3020_0010;
    vec[4] = 65'h0_0000_0000_0000_0001;
    vec[5] = 65'h1_0F0F_A5A5_5A5A_F0F0;

    rst_n = 1'b0; in_valid = 1'b0; in_word = '0; stall = 1'b0; flush = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    // Reset state
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_word", out_word, NOP);
    check("rst_occupancy", occupancy, 2'd0);
    check("rst_out_first", out_first, 1'b0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", in_ready, 1'b1);
    mon_en = 1; chk_lat = 1;

    // T1: single word, no stall
    in_valid = 1'b1; in_word = vec[0];
    edge_step();
    in_valid = 1'b0;
    check("t1_not_early", out_valid, 1'b0);
    edge_step();
    check("t1_valid_edge2", out_valid, 1'b1);
    check("t1_word_edge2", out_word, vec[0]);
    edge_step();
    check("t1_word_after", out_word, NOP);
    edge_step();

    // T2: same word held for three stall cycles
    in_valid = 1'b1; in_word = vec[0];
    edge_step();
    in_valid = 1'b0;
    edge_step();
    stall = 1'b1;
    edge_step();
    check("t2_held_bit21", out_word[21], 1'b0);
    check("t2_held_bit32", out_word[32], 1'b1);
    check("t2_held_bit4", out_word[4], 1'b1);
    edge_step();
    edge_step();
    stall = 1'b0;
    edge_step();
    edge_step();

    // T3: six words back-to-back
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_word = vec[i];
      check("t3_in_ready", in_ready, 1'b1);
      edge_step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) edge_step();

    // T4: fill under stall, then release
    chk_lat = 0;
    stall = 1'b1;
    in_valid = 1'b1; in_word = vec[2];
    edge_step();
    in_word = vec[5];
    edge_step();
    check("t4_occ_full", occupancy, 2'd2);
    check("t4_ready_full", in_ready, 1'b0);
    in_word = vec[1];
    edge_step();
    check("t4_occ_still", occupancy, 2'd2);
    check("t4_ready_still", in_ready, 1'b0);
    stall = 1'b0;
    #1;
    check("t4_ready_pass", in_ready, 1'b1);
    edge_step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) edge_step();
    check("t4_occ_drained", occupancy, 2'd0);

    // T5: flush a full pipe with input pending
    stall = 1'b1;
    in_valid = 1'b1; in_word = vec[3];
    edge_step();
    in_word = vec[4];
    edge_step();
    check("t5_occ_full", occupancy, 2'd2);
    in_word = vec[1]; flush = 1'b1;
    #1;
    check("t5_ready_flush", in_ready, 1'b0);
    edge_step();
    flush = 1'b0; in_valid = 1'b0;
    check("t5_occ", occupancy, 2'd0);
    check("t5_out_valid", out_valid, 1'b0);
    check("t5_out_word", out_word, NOP);
    stall = 1'b0;
    for (int i = 0; i < 3; i++) edge_step();

    // T6: reset pulse while streaming
    chk_lat = 1;
    in_valid = 1'b1; in_word = vec[2];
    edge_step();
    in_word = vec[3];
    edge_step();
    in_word = vec[5]; rst_n = 1'b0;
    #1;
    check("t6_ready_rst", in_ready, 1'b0);
    edge_step();
    check("t6_out_valid", out_valid, 1'b0);
    check("t6_out_word", out_word, NOP);
    check("t6_occ", occupancy, 2'd0);
    check("t6_first", out_first, 1'b0);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    check("t6_ready_rel", in_ready, 1'b1);
    in_valid = 1'b1; in_word = vec[1];
    edge_step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) edge_step();

    // Drain with a bounded wait
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d words pending, required 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
